// File: rtl/pciecfg_pkg.sv
// pciecfg_pkg: shared types for the PCIe configuration-access path.
//   FIFO_PCIECFG_T      - request word read from the inbound config FIFO
//   FIFO_PCIECFG_RESP_T - response word pushed into the outbound FIFO
//   PCIECFG_ST_*        - response status codes
//   pciecfg_resp_state_t - responder FSM state encoding
package pciecfg_pkg;

    typedef struct packed {
        logic [15:0] seq;
        logic        write;
        logic [3:0]  byte_en;
        logic [9:0]  dwaddr;
        logic [31:0] data;
    } FIFO_PCIECFG_T;

    typedef struct packed {
        logic [15:0] seq;
        logic        write;
        logic        status;
        logic [31:0] data;
    } FIFO_PCIECFG_RESP_T;

    localparam logic PCIECFG_ST_OK      = 1'b0;
    localparam logic PCIECFG_ST_TIMEOUT = 1'b1;

    // Data returned for an access the core never completed.
    localparam logic [31:0] PCIECFG_TIMEOUT_DATA = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LATCH,
        ST_ISSUE,
        ST_RESP
    } pciecfg_resp_state_t;

endpackage

// File: rtl/pciecfg_responder.sv
// pciecfg_responder: pops one config request at a time from the inbound
// FIFO, runs it on the 7-series cfg_mgmt port and pushes one response.
// Ports:
//   clk, rst_n                 - core clock, asynchronous active-low reset
//   in_dout/in_empty/in_rd_en  - request FIFO read port (data valid the
//                                cycle after in_rd_en)
//   out_din/out_full/out_wr_en - response FIFO write port
//   cfg_mgmt_*                 - PCIe core configuration management port
//   busy                       - FSM not idle
//   req_count/timeout_count    - completed / timed-out request counters
// Every output is a flop; the "next" values are computed from the
// next state so that strobes line up with the state they belong to.
module pciecfg_responder
    import pciecfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [$bits(FIFO_PCIECFG_T)-1:0]   in_dout,
    input  logic                               in_empty,
    output logic                               in_rd_en,
    output logic [$bits(FIFO_PCIECFG_RESP_T)-1:0] out_din,
    input  logic                               out_full,
    output logic                               out_wr_en,
    input  logic [31:0]                        cfg_mgmt_do,
    input  logic                               cfg_mgmt_rd_wr_done,
    output logic [31:0]                        cfg_mgmt_di,
    output logic [3:0]                         cfg_mgmt_byte_en,
    output logic [9:0]                         cfg_mgmt_dwaddr,
    output logic                               cfg_mgmt_wr_en,
    output logic                               cfg_mgmt_rd_en,
    output logic                               cfg_mgmt_wr_readonly,
    output logic                               busy,
    output logic [31:0]                        req_count,
    output logic [15:0]                        timeout_count
);

    // Counter value in the last strobe cycle before giving up.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    pciecfg_resp_state_t state_reg, state_next;

    FIFO_PCIECFG_T      in_req;
    FIFO_PCIECFG_RESP_T out_din_reg;

    // Request register: seq/write kept here, address/enables/data live
    // directly in the cfg_mgmt output flops.
    logic [15:0] req_seq_reg;
    logic        req_write_reg;
    logic [15:0] tcnt_reg;
    logic        resp_status_reg;
    logic [31:0] resp_data_reg;

    logic        in_rd_en_reg, out_wr_en_reg, busy_reg;
    logic        wr_en_reg, rd_en_reg;
    logic [31:0] di_reg;
    logic [3:0]  byte_en_reg;
    logic [9:0]  dwaddr_reg;
    logic [31:0] req_count_reg;
    logic [15:0] timeout_count_reg;

    logic timeout_hit, push;
    logic in_rd_en_next, out_wr_en_next, busy_next, wr_en_next, rd_en_next;
    logic strobe_next, cur_write;

    assign in_req = in_dout;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. A done pulse is only looked at in ISSUE and
    // takes priority over an expiring timeout in the same cycle.
    always_comb begin
        state_next  = state_reg;
        timeout_hit = (state_reg == ST_ISSUE) && !cfg_mgmt_rd_wr_done &&
                      (tcnt_reg == TIMEOUT_LAST);
        // RESP lasts two cycles minimum: one to decide the push, one in
        // which the registered out_wr_en pulse is actually presented.
        push        = (state_reg == ST_RESP) && !out_wr_en_reg && !out_full;
        case (state_reg)
            ST_IDLE:  if (!in_empty) state_next = ST_POP;
            ST_POP:   state_next = ST_LATCH;
            ST_LATCH: state_next = ST_ISSUE;
            ST_ISSUE: if (cfg_mgmt_rd_wr_done || timeout_hit) state_next = ST_RESP;
            ST_RESP:  if (out_wr_en_reg) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        in_rd_en_next  = (state_next == ST_POP);
        busy_next      = (state_next != ST_IDLE);
        strobe_next    = (state_next == ST_ISSUE);
        // On the LATCH edge the request register is not loaded yet.
        cur_write      = (state_reg == ST_LATCH) ? in_req.write : req_write_reg;
        wr_en_next     = strobe_next && cur_write;
        rd_en_next     = strobe_next && !cur_write;
        out_wr_en_next = push;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_seq_reg       <= '0;
            req_write_reg     <= 1'b0;
            tcnt_reg          <= '0;
            resp_status_reg   <= PCIECFG_ST_OK;
            resp_data_reg     <= '0;
            in_rd_en_reg      <= 1'b0;
            out_wr_en_reg     <= 1'b0;
            busy_reg          <= 1'b0;
            wr_en_reg         <= 1'b0;
            rd_en_reg         <= 1'b0;
            di_reg            <= '0;
            byte_en_reg       <= '0;
            dwaddr_reg        <= '0;
            out_din_reg       <= '0;
            req_count_reg     <= '0;
            timeout_count_reg <= '0;
        end else begin
            in_rd_en_reg  <= in_rd_en_next;
            out_wr_en_reg <= out_wr_en_next;
            busy_reg      <= busy_next;
            wr_en_reg     <= wr_en_next;
            rd_en_reg     <= rd_en_next;

            if (state_reg == ST_LATCH) begin
                req_seq_reg   <= in_req.seq;
                req_write_reg <= in_req.write;
                di_reg        <= in_req.data;
                byte_en_reg   <= in_req.byte_en;
                dwaddr_reg    <= in_req.dwaddr;
                tcnt_reg      <= '0;
            end else if (state_reg == ST_ISSUE) begin
                if (cfg_mgmt_rd_wr_done) begin
                    resp_status_reg <= PCIECFG_ST_OK;
                    resp_data_reg   <= req_write_reg ? 32'h0 : cfg_mgmt_do;
                end else if (timeout_hit) begin
                    resp_status_reg <= PCIECFG_ST_TIMEOUT;
                    resp_data_reg   <= PCIECFG_TIMEOUT_DATA;
                end else begin
                    tcnt_reg <= tcnt_reg + 16'd1;
                end
            end

            if (push) begin
                out_din_reg   <= '{seq: req_seq_reg, write: req_write_reg,
                                   status: resp_status_reg, data: resp_data_reg};
                req_count_reg <= req_count_reg + 32'd1;
                if (resp_status_reg == PCIECFG_ST_TIMEOUT && timeout_count_reg != 16'hFFFF) begin
                    timeout_count_reg <= timeout_count_reg + 16'd1;
                end
            end
        end
    end

    assign in_rd_en             = in_rd_en_reg;
    assign out_wr_en            = out_wr_en_reg;
    assign out_din              = out_din_reg;
    assign busy                 = busy_reg;
    assign cfg_mgmt_wr_en       = wr_en_reg;
    assign cfg_mgmt_rd_en       = rd_en_reg;
    assign cfg_mgmt_di          = di_reg;
    assign cfg_mgmt_byte_en     = byte_en_reg;
    assign cfg_mgmt_dwaddr      = dwaddr_reg;
    assign cfg_mgmt_wr_readonly = 1'b0;
    assign req_count            = req_count_reg;
    assign timeout_count        = timeout_count_reg;

endmodule

// File: tb/tb_pciecfg_responder.sv
// tb_pciecfg_responder: directed requests with hand-computed responses.
// Requests go into a FIFO model; expected responses go into a scoreboard
// queue that a negedge monitor pops whenever out_wr_en is seen. The core
// model answers per DWORD address with a fixed delay (or never).
module tb_pciecfg_responder;
    import pciecfg_pkg::*;

    localparam int TO = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    FIFO_PCIECFG_T      in_dout = '0;
    logic               in_empty = 1'b1;
    logic               in_rd_en;
    FIFO_PCIECFG_RESP_T out_din;
    logic               out_full = 1'b0;
    logic               out_wr_en;
    logic [31:0]        cfg_mgmt_do;
    logic               cfg_mgmt_rd_wr_done;
    logic [31:0]        cfg_mgmt_di;
    logic [3:0]         cfg_mgmt_byte_en;
    logic [9:0]         cfg_mgmt_dwaddr;
    logic               cfg_mgmt_wr_en, cfg_mgmt_rd_en, cfg_mgmt_wr_readonly;
    logic               busy;
    logic [31:0]        req_count;
    logic [15:0]        timeout_count;

    always #5 clk = ~clk;

    pciecfg_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
        .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en),
        .cfg_mgmt_do(cfg_mgmt_do), .cfg_mgmt_rd_wr_done(cfg_mgmt_rd_wr_done),
        .cfg_mgmt_di(cfg_mgmt_di), .cfg_mgmt_byte_en(cfg_mgmt_byte_en),
        .cfg_mgmt_dwaddr(cfg_mgmt_dwaddr), .cfg_mgmt_wr_en(cfg_mgmt_wr_en),
        .cfg_mgmt_rd_en(cfg_mgmt_rd_en), .cfg_mgmt_wr_readonly(cfg_mgmt_wr_readonly),
        .busy(busy), .req_count(req_count), .timeout_count(timeout_count)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int resp_seen = 0;
    int pops = 0;

    FIFO_PCIECFG_T      req_q[$];
    FIFO_PCIECFG_RESP_T exp_q[$];
    int                 pop_cyc[$];

    // Core model: per-address completion delay in strobe cycles (-1 = never).
    int          delay_by_addr [0:1023];
    logic [31:0] do_by_addr    [0:1023];
    int          strobe_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n || !(cfg_mgmt_rd_en || cfg_mgmt_wr_en)) strobe_cnt <= 0;
        else strobe_cnt <= strobe_cnt + 1;
    end

    assign cfg_mgmt_do = do_by_addr[cfg_mgmt_dwaddr];
    assign cfg_mgmt_rd_wr_done = (cfg_mgmt_rd_en || cfg_mgmt_wr_en) &&
                                 (delay_by_addr[cfg_mgmt_dwaddr] >= 0) &&
                                 (strobe_cnt == delay_by_addr[cfg_mgmt_dwaddr]);

    // Request FIFO model: data appears the cycle after the pop.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_rd_en && req_q.size() > 0) in_dout <= req_q.pop_front();
    end
    always @(clk) #1 in_empty = (req_q.size() == 0);

    // Strobe burst tracker
    int   cur_len = 0, last_len = 0;
    logic cur_rd = 1'b0, cur_both = 1'b0, last_rd = 1'b0;

    always @(negedge clk) begin
        if (in_rd_en) begin
            pops++;
            pop_cyc.push_back(cyc);
        end
        if (cfg_mgmt_rd_en || cfg_mgmt_wr_en) begin
            cur_len++;
            if (cfg_mgmt_rd_en) cur_rd = 1'b1;
            if (cfg_mgmt_rd_en && cfg_mgmt_wr_en) cur_both = 1'b1;
        end else if (cur_len > 0) begin
            last_len = cur_len;
            last_rd  = cur_rd;
            checks++;
            if (cur_both) begin
                errors++;
                $display("FAIL strobe_exclusive: rd_en and wr_en both high, required never");
            end
            cur_len = 0; cur_rd = 1'b0; cur_both = 1'b0;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (out_wr_en) begin
            resp_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got %h, required no push", out_din);
            end else begin
                FIFO_PCIECFG_RESP_T e;
                e = exp_q.pop_front();
                if (out_din !== e) begin
                    errors++;
                    $display("FAIL resp: got %h required %h", out_din, e);
                end else begin
                    $display("resp seq=%h write=%0d status=%0d data=%h ok",
                             out_din.seq, out_din.write, out_din.status, out_din.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic push_req(input logic [15:0] s, input logic w, input logic [3:0] be,
                            input logic [9:0] a, input logic [31:0] d);
        FIFO_PCIECFG_T r;
        r.seq = s; r.write = w; r.byte_en = be; r.dwaddr = a; r.data = d;
        req_q.push_back(r);
        $display("req  seq=%h write=%0d be=%h addr=%h data=%h", s, w, be, a, d);
    endtask

    task automatic expect_resp(input logic [15:0] s, input logic w, input logic st,
                               input logic [31:0] d);
        FIFO_PCIECFG_RESP_T r;
        r.seq = s; r.write = w; r.status = st; r.data = d;
        exp_q.push_back(r);
    endtask

    task automatic wait_resp(input int n, input int budget);
        int k;
        k = 0;
        while (resp_seen < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (resp_seen < n) begin
            errors++; checks++;
            $display("FAIL wait_resp: got %0d responses required %0d", resp_seen, n);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy || req_q.size() != 0) && k < 200);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({in_rd_en, out_wr_en, cfg_mgmt_wr_en, cfg_mgmt_rd_en,
                                cfg_mgmt_wr_readonly, busy}), 64'h0);
        chk({tag, "_out_din"}, 64'(out_din), 64'h0);
        chk({tag, "_cfg_bus"}, 64'({cfg_mgmt_di, cfg_mgmt_byte_en, cfg_mgmt_dwaddr}), 64'h0);
        chk({tag, "_counters"}, 64'({req_count, timeout_count}), 64'h0);
    endtask

    initial begin
        int k, base, t0;
        for (int i = 0; i < 1024; i++) begin
            delay_by_addr[i] = 0;
            do_by_addr[i]    = 32'hA500_0000 | 32'(i);
        end
        delay_by_addr[10'h004] = 2;  do_by_addr[10'h004] = 32'h0010_0007;
        delay_by_addr[10'h3FF] = -1;
        delay_by_addr[10'h010] = 1;  do_by_addr[10'h010] = 32'h1111_0010;
        delay_by_addr[10'h011] = 1;  do_by_addr[10'h011] = 32'h2222_0011;
        delay_by_addr[10'h012] = 1;  do_by_addr[10'h012] = 32'h3333_0012;
        do_by_addr[10'h020] = 32'hC000_0020;
        do_by_addr[10'h021] = 32'hC000_0021;
        do_by_addr[10'h022] = 32'hC000_0022;
        delay_by_addr[10'h023] = TO - 1;  do_by_addr[10'h023] = 32'hC000_0023;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read, done 2 cycles after the first strobe cycle
        push_req(16'h0012, 1'b0, 4'hF, 10'h004, 32'h0);
        expect_resp(16'h0012, 1'b0, PCIECFG_ST_OK, 32'h0010_0007);
        wait_resp(1, 40);
        chk("read_rd_len", 64'(last_len), 64'd3);
        chk("read_is_rd", 64'(last_rd), 64'd1);
        chk("read_req_count", 64'(req_count), 64'd1);
        wait_idle();

        // Write with byte enables 0x3
        push_req(16'h0034, 1'b1, 4'h3, 10'h001, 32'h0000_0406);
        expect_resp(16'h0034, 1'b1, PCIECFG_ST_OK, 32'h0);
        k = 0;
        while (!cfg_mgmt_wr_en && k < 20) begin @(negedge clk); k++; end
        chk("write_bus", 64'({cfg_mgmt_wr_en, cfg_mgmt_di, cfg_mgmt_byte_en, cfg_mgmt_dwaddr}),
            64'({1'b1, 32'h0000_0406, 4'h3, 10'h001}));
        wait_resp(2, 40);
        chk("write_no_rd", 64'(last_rd), 64'd0);
        wait_idle();

        // Timeout
        push_req(16'h0056, 1'b0, 4'hF, 10'h3FF, 32'h0);
        expect_resp(16'h0056, 1'b0, PCIECFG_ST_TIMEOUT, 32'hFFFF_FFFF);
        wait_resp(3, 60);
        chk("timeout_len", 64'(last_len), 64'(TO));
        chk("timeout_count", 64'(timeout_count), 64'd1);
        chk("timeout_req_count", 64'(req_count), 64'd3);
        wait_idle();

        // Backpressure and ordering
        out_full = 1'b1;
        base = pops;
        push_req(16'h0101, 1'b0, 4'hF, 10'h010, 32'h0);
        push_req(16'h0102, 1'b0, 4'hF, 10'h011, 32'h0);
        push_req(16'h0103, 1'b0, 4'hF, 10'h012, 32'h0);
        expect_resp(16'h0101, 1'b0, PCIECFG_ST_OK, 32'h1111_0010);
        expect_resp(16'h0102, 1'b0, PCIECFG_ST_OK, 32'h2222_0011);
        expect_resp(16'h0103, 1'b0, PCIECFG_ST_OK, 32'h3333_0012);
        repeat (20) @(negedge clk);
        chk("stall_pops", 64'(pops - base), 64'd1);
        chk("stall_resps", 64'(resp_seen), 64'd3);
        out_full = 1'b0;
        wait_resp(6, 100);
        chk("bp_req_count", 64'(req_count), 64'd6);
        wait_idle();

        // Back-to-back with immediate done; last entry done coincides with timeout
        pop_cyc.delete();
        t0 = cyc;
        push_req(16'h0201, 1'b0, 4'hF, 10'h020, 32'h0);
        push_req(16'h0202, 1'b0, 4'hF, 10'h021, 32'h0);
        push_req(16'h0203, 1'b0, 4'hF, 10'h022, 32'h0);
        push_req(16'h0204, 1'b0, 4'hF, 10'h023, 32'h0);
        expect_resp(16'h0201, 1'b0, PCIECFG_ST_OK, 32'hC000_0020);
        expect_resp(16'h0202, 1'b0, PCIECFG_ST_OK, 32'hC000_0021);
        expect_resp(16'h0203, 1'b0, PCIECFG_ST_OK, 32'hC000_0022);
        expect_resp(16'h0204, 1'b0, PCIECFG_ST_OK, 32'hC000_0023);
        wait_resp(10, 100);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_pop%0d_cycle", i),
                64'((pop_cyc.size() > i) ? pop_cyc[i] - t0 : -1), 64'(1 + 6 * i));
        end
        chk("b2b_last_len", 64'(last_len), 64'(TO));
        chk("b2b_counts", 64'({req_count, timeout_count}), 64'({32'd10, 16'd1}));
        wait_idle();

        // Reset in the middle of ISSUE
        push_req(16'h0099, 1'b0, 4'hF, 10'h3FF, 32'h0);
        k = 0;
        while (!cfg_mgmt_rd_en && k < 20) begin @(negedge clk); k++; end
        chk("rst_rd_seen", 64'(cfg_mgmt_rd_en), 64'd1);
        base = resp_seen;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        repeat (3) @(negedge clk);
        chk("rst_no_push", 64'(resp_seen - base), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_req(16'h0077, 1'b0, 4'hF, 10'h004, 32'h0);
        expect_resp(16'h0077, 1'b0, PCIECFG_ST_OK, 32'h0010_0007);
        wait_resp(base + 1, 40);
        chk("post_rst_req_count", 64'(req_count), 64'd1);
        chk("post_rst_exp_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
